// File: rtl/axi4lite_master_arbiter_if.sv
// AXI4-Lite channel bundle between the arbiter (master) and a register slave.
// Signal names match the AXI channel names used by axi4lite_slave / reg_bank.
interface axi4lite_master_arbiter_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);
  logic                      AW_VALID;
  logic                      AW_READY;
  logic [AXI_ADDR_WIDTH-1:0] AW_ADDR;
  logic                      W_VALID;
  logic                      W_READY;
  logic [AXI_DATA_WIDTH-1:0] W_DATA;
  logic                      B_VALID;
  logic                      B_READY;
  logic [1:0]                B_RESP;
  logic                      AR_VALID;
  logic                      AR_READY;
  logic [AXI_ADDR_WIDTH-1:0] AR_ADDR;
  logic                      R_VALID;
  logic                      R_READY;
  logic [AXI_DATA_WIDTH-1:0] R_DATA;
  logic [1:0]                R_RESP;

  modport master (
    output AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
    input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );

  modport slave (
    input  AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
    output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );
endinterface

// File: rtl/axi4lite_master_arbiter.sv
// Two-requester round-robin arbiter that runs one AXI4-Lite transaction at a
// time on a shared master port and returns data/response with a one-cycle ACK.
module axi4lite_master_arbiter #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                        A_CLK,
  input  logic                        A_RSTn,
  input  logic [1:0]                  REQ,
  input  logic [1:0]                  REQ_WE,
  input  logic [2*AXI_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [2*AXI_DATA_WIDTH-1:0] REQ_WDATA,
  output logic [1:0]                  ACK,
  output logic [AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                  RSP_RESP,
  axi4lite_master_arbiter_if.master   m_axi
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rr_ptr;
  logic            r_gnt;
  logic            r_aw_done;
  logic            r_w_done;
  logic [AW-1:0]   r_aw_addr;
  logic [AW-1:0]   r_ar_addr;
  logic [DW-1:0]   r_w_data;
  logic [DW-1:0]   r_rsp_rdata;
  logic [1:0]      r_rsp_resp;

  logic            w_win;
  logic [AW-1:0]   w_win_addr;
  logic [DW-1:0]   w_win_wdata;
  logic            w_aw_valid;
  logic            w_w_valid;
  logic            w_b_ready;
  logic            w_ar_valid;
  logic            w_r_ready;
  logic [1:0]      w_ack;

  // r_rr_ptr names the requester that wins the next tie.
  always_comb begin
    w_win = 1'b0;
    if (REQ == 2'b11) w_win = r_rr_ptr;
    else              w_win = REQ[1];
    w_win_addr  = w_win ? REQ_ADDR[2*AW-1:AW]  : REQ_ADDR[AW-1:0];
    w_win_wdata = w_win ? REQ_WDATA[2*DW-1:DW] : REQ_WDATA[DW-1:0];
  end

  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_aw_valid  = 1'b0;
    w_w_valid   = 1'b0;
    w_b_ready   = 1'b0;
    w_ar_valid  = 1'b0;
    w_r_ready   = 1'b0;
    w_ack       = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (|REQ) w_state_nxt = REQ_WE[w_win] ? S_WR_REQ : S_RD_REQ;
      end
      S_WR_REQ: begin
        w_aw_valid = !r_aw_done;
        w_w_valid  = !r_w_done;
        // Both channels may complete in the same cycle or in either order.
        if ((r_aw_done || m_axi.AW_READY) && (r_w_done || m_axi.W_READY))
          w_state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        w_b_ready = 1'b1;
        if (m_axi.B_VALID) w_state_nxt = S_DONE;
      end
      S_RD_REQ: begin
        w_ar_valid = 1'b1;
        if (m_axi.AR_READY) w_state_nxt = S_RD_RESP;
      end
      S_RD_RESP: begin
        w_r_ready = 1'b1;
        if (m_axi.R_VALID) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_ack       = r_gnt ? 2'b10 : 2'b01;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      r_rr_ptr    <= 1'b0;
      r_gnt       <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_aw_addr   <= '0;
      r_ar_addr   <= '0;
      r_w_data    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|REQ) begin
            r_gnt     <= w_win;
            r_rr_ptr  <= ~w_win;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (REQ_WE[w_win]) begin
              r_aw_addr <= w_win_addr;
              r_w_data  <= w_win_wdata;
            end else begin
              r_ar_addr <= w_win_addr;
            end
          end
        end
        S_WR_REQ: begin
          if (w_aw_valid && m_axi.AW_READY) r_aw_done <= 1'b1;
          if (w_w_valid && m_axi.W_READY)   r_w_done  <= 1'b1;
        end
        S_WR_RESP: begin
          if (m_axi.B_VALID) r_rsp_resp <= m_axi.B_RESP;
        end
        S_RD_RESP: begin
          if (m_axi.R_VALID) begin
            r_rsp_rdata <= m_axi.R_DATA;
            r_rsp_resp  <= m_axi.R_RESP;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi.AW_VALID = w_aw_valid;
  assign m_axi.AW_ADDR  = r_aw_addr;
  assign m_axi.W_VALID  = w_w_valid;
  assign m_axi.W_DATA   = r_w_data;
  assign m_axi.B_READY  = w_b_ready;
  assign m_axi.AR_VALID = w_ar_valid;
  assign m_axi.AR_ADDR  = r_ar_addr;
  assign m_axi.R_READY  = w_r_ready;
  assign ACK            = w_ack;
  assign RSP_RDATA      = r_rsp_rdata;
  assign RSP_RESP       = r_rsp_resp;

endmodule

// File: doc/axi4lite_master_arbiter.md
Name: axi4lite_master_arbiter

Overview:
- Two-requester round-robin arbiter and AXI4-Lite master sequencer.
- Two local requesters issue single read/write commands on a simple req/ack interface. The block grants one requester at a time and runs exactly one AXI4-Lite transaction on the shared master port, which connects to axi4lite_slave / reg_bank.
- Only one transaction is outstanding at any time. It returns read data and the response code to the granted requester.

Parameters:
- AXI_ADDR_WIDTH, 32, address width of the local and AXI address buses.
- AXI_DATA_WIDTH, 32, data width of the local and AXI data buses.

Ports:
- A_CLK  in  1  clock.
- A_RSTn  in  1  reset, asynchronous assert, active-low.
- REQ  in  2  per-requester request; bit i belongs to requester i.
- REQ_WE  in  2  per-requester direction: 1 = write, 0 = read.
- REQ_ADDR  in  2*AXI_ADDR_WIDTH  requester i address at slice [i*AW +: AW].
- REQ_WDATA  in  2*AXI_DATA_WIDTH  requester i write data at slice [i*DW +: DW].
- ACK  out  2  one-cycle completion pulse to the granted requester.
- RSP_RDATA  out  AXI_DATA_WIDTH  read data, shared by both requesters, valid while ACK is high.
- RSP_RESP  out  2  B_RESP/R_RESP of the completed transaction, valid while ACK is high.
- AW_VALID, AW_READY(in), AW_ADDR  AXI write-address channel.
- W_VALID, W_READY(in), W_DATA  AXI write-data channel.
- B_VALID(in), B_READY, B_RESP(in)  AXI write-response channel.
- AR_VALID, AR_READY(in), AR_ADDR  AXI read-address channel.
- R_VALID(in), R_READY, R_DATA(in), R_RESP(in)  AXI read-data channel.

Behaviour:
- Reset:
  - State = IDLE; rr_ptr = 0, meaning requester 0 wins the first tie.
  - All VALID/READY outputs, ACK, AW_ADDR, AR_ADDR, W_DATA, RSP_RDATA and RSP_RESP = 0.
  - Reset asserted mid-transaction aborts it immediately: no ACK is issued and all channel valids drop asynchronously.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE, arbitration:
  - Sampled only in IDLE. With a single REQ bit set, that requester is granted.
  - With both set, the requester != rr_ptr-last-winner is granted.
  - rr_ptr updates on grant.
  - On grant, latch REQ_WE, address and wdata of the winner into AW_ADDR/W_DATA or AR_ADDR.
  - Go to WR_REQ if WE=1, else RD_REQ.
- WR_REQ:
  - AW_VALID and W_VALID are both asserted on state entry.
  - Each drops independently the cycle after its own handshake (VALID&&READY).
  - Go to WR_RESP once both handshakes are done; this includes same-cycle completion of both.
  - VALID is never withdrawn before its handshake.
  - Address and data are held stable while VALID is high.
- WR_RESP: B_READY = 1. On B_VALID, capture B_RESP into RSP_RESP, drop B_READY, go to DONE.
- RD_REQ: AR_VALID = 1 until the AR handshake, then go to RD_RESP.
- RD_RESP: R_READY = 1. On R_VALID, capture R_DATA and R_RESP, go to DONE.
- DONE:
  - ACK[granted] = 1 for exactly one cycle, then IDLE.
  - RSP_RDATA/RSP_RESP hold their values until the next capture.
  - Writes leave RSP_RDATA unchanged.
- Requester rules:
  - A requester holds REQ and its operands until it sees ACK, and must deassert REQ the cycle after ACK.
  - REQ still high in the following IDLE is treated as a new command.
  - Dropping REQ after grant does not cancel the transaction.
- Latency:
  - Minimum 4 cycles from REQ sampled in IDLE to return to IDLE, when the slave is always ready and responds in the next cycle.
  - The cycle of the ACK is REQ-sample cycle + 3.
- RESP codes (SLVERR/DECERR) are passed through unchanged; no retry.
- Never more than one AXI transaction outstanding. AW/W and AR are never active in the same cycle.

Test Plan:
- Single write:
  - Stimulus: REQ=01, WE=1, ADDR0=0x4, WDATA0=0xDEADBEEF; slave ready.
  - Response: AW_VALID=W_VALID=1 with AW_ADDR=0x4, W_DATA=0xDEADBEEF; B_READY next; ACK=01 at REQ cycle+3 with RSP_RESP=00.
- Single read:
  - Stimulus: REQ=10, WE=0, ADDR1=0x4 after the write.
  - Response: AR_ADDR=0x4; ACK=10 with RSP_RDATA=0xDEADBEEF, RSP_RESP=00.
- Contention:
  - Stimulus: REQ=11 continuously, both requesters reading.
  - Response: grants alternate 0,1,0,1; each ACK is exactly one cycle; no overlapping AR_VALID.
- Backpressure:
  - Stimulus: W_READY held 0 for 3 cycles after AW handshake.
  - Response: AW_VALID drops after its handshake; W_VALID/W_DATA stay stable; B_READY is only asserted after the W handshake.
- Error passthrough:
  - Stimulus: slave returns R_RESP=10 on a read.
  - Response: RSP_RESP=10 during ACK.
- Reset mid-op:
  - Stimulus: A_RSTn low during WR_RESP.
  - Response: all outputs 0 immediately; no ACK; first REQ=11 after release grants requester 0.
